// File: rtl/fp_pkg.sv
// Shared IEEE754 single-precision field layout, class encodings and the result
// FIFO entry type. FP_RESULT_CLASSIFY_EN adds a stored class field to each entry.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  typedef enum logic [2:0] {
    CLS_ZERO      = 3'd0,
    CLS_SUBNORMAL = 3'd1,
    CLS_NORMAL    = 3'd2,
    CLS_INF       = 3'd3,
    CLS_NAN       = 3'd4
  } fp_class_e;

  typedef struct packed {
`ifdef FP_RESULT_CLASSIFY_EN
    logic [2:0]      cls;
`endif
    logic [FP_W-1:0] data;
    logic            ovf;
    logic            unf;
  } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE754 single-precision classifier; the sign bit does not
// affect the class, so only exponent and mantissa are taken in.
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W+MAN_W-1:0] mag,
  output logic [2:0]             cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = mag[MAN_W +: EXP_W];
  assign man_f = mag[MAN_W-1:0];

  always_comb begin
    if (exp_f == '0) begin
      cls = (man_f == '0) ? CLS_ZERO : CLS_SUBNORMAL;
    end else if (exp_f == '1) begin
      cls = (man_f == '0) ? CLS_INF : CLS_NAN;
    end else begin
      cls = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/fp_result_collect.sv
// Edge-captures square-stage results into a first-word-fall-through FIFO with
// a saturating drop counter. Optional macro FP_RESULT_CLASSIFY_EN adds out_class.
module fp_result_collect
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            result,
  input  logic                   overflow,
  input  logic                   underflow,
  input  logic                   enable,
  output logic [31:0]            out_data,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
`ifdef FP_RESULT_CLASSIFY_EN
  ,
  output logic [2:0]             out_class
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HELD = 1'b1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  logic             state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;
  fp_entry_t        mem_q [DEPTH];

  fp_entry_t new_entry;
  fp_entry_t head;
  logic      head_valid;
  logic      full;
  logic      push_req;
  logic      push;
  logic      pop;
  logic      drop;

  // One push per enable pulse: only the IDLE->HELD transition captures.
  assign push_req   = (state_q == ST_IDLE) && enable;
  assign head_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop        = head_valid && out_ready;
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

`ifdef FP_RESULT_CLASSIFY_EN
  logic [2:0] new_cls;

  fp_classify u_classify (
    .mag (result[EXP_W+MAN_W-1:0]),
    .cls (new_cls)
  );
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    new_entry      = '0;
    new_entry.data = result;
    new_entry.ovf  = overflow;
    new_entry.unf  = underflow;
`ifdef FP_RESULT_CLASSIFY_EN
    new_entry.cls  = new_cls;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_HELD;
      ST_HELD: if (!enable) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count already discards it.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = head_valid;
  assign out_data  = head_valid ? head.data : '0;
  assign out_ovf   = head_valid && head.ovf;
  assign out_unf   = head_valid && head.unf;
  assign count     = count_q;
  assign drop_cnt  = drop_q;
`ifdef FP_RESULT_CLASSIFY_EN
  assign out_class = head_valid ? head.cls : 3'd0;
`endif

endmodule

// File: tb/tb_fp_result_collect.sv
// Self-checking bench for fp_result_collect: a constant-expectation vector table,
// hand-written corner sequences and a randomized run against a queue-based model.
module tb_fp_result_collect;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] result = '0;
  logic        overflow = 1'b0;
  logic        underflow = 1'b0;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_valid;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
`ifdef FP_RESULT_CLASSIFY_EN
  logic [2:0]  out_class;
`endif

  int errors = 0;
  int checks = 0;

  fp_result_collect #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .enable    (enable),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
`ifdef FP_RESULT_CLASSIFY_EN
    ,
    .out_class (out_class)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of captured results in arrival order.
  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic [2:0]  cls;
  } ent_t;

  ent_t mq[$];
  int   m_drops = 0;
  bit   m_held  = 0;

  function automatic logic [2:0] class_of(input logic [31:0] v);
    int unsigned e, m;
    e = (v >> 23) & 32'hFF;
    m = v & 32'h7FFFFF;
    if (e == 0)   return (m == 0) ? 3'd0 : 3'd1;
    if (e == 255) return (m == 0) ? 3'd3 : 3'd4;
    return 3'd2;
  endfunction

  task automatic compare_model();
    logic [31:0] ed;
    logic        eo, eu;
    logic [2:0]  ec;
    ed = '0; eo = 0; eu = 0; ec = '0;
    if (mq.size() > 0) begin
      ed = mq[0].data; eo = mq[0].ovf; eu = mq[0].unf; ec = mq[0].cls;
    end
    check("out_valid", out_valid, mq.size() > 0);
    check("count", count, mq.size());
    check("drop_cnt", drop_cnt, m_drops);
    check("out_data", out_data, ed);
    check("out_ovf", out_ovf, eo);
    check("out_unf", out_unf, eu);
`ifdef FP_RESULT_CLASSIFY_EN
    check("out_class", out_class, ec);
`else
    if (ec > 3'd4) check("model_class", ec, 3'd0);
`endif
  endtask

  // Applies one cycle of inputs, advances the model, then compares after the edge.
  task automatic cycle(input logic en, input logic [31:0] res,
                       input logic ov, input logic un, input logic rdy);
    bit   do_push, do_pop, was_full;
    ent_t e;
    enable = en; result = res; overflow = ov; underflow = un; out_ready = rdy;
    do_push  = en && !m_held;
    do_pop   = (mq.size() > 0) && rdy;
    was_full = (mq.size() == DEPTH);
    e = '{data: res, ovf: ov, unf: un, cls: class_of(res)};
    @(posedge CLK);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (!was_full || do_pop) mq.push_back(e);
      else if (m_drops < 255) m_drops++;
    end
    m_held = en;
    compare_model();
  endtask

  task automatic pulse(input logic [31:0] v, input logic rdy);
    cycle(1'b1, v, 1'b0, 1'b0, rdy);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without an edge.
  task automatic do_reset(input logic hold_en);
    RST = 1'b0;
    enable = hold_en;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", {out_ovf, out_unf}, 2'b00);
`ifdef FP_RESULT_CLASSIFY_EN
    check("rst_out_class", out_class, 3'd0);
`endif
    mq.delete();
    m_drops = 0;
    m_held  = 0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [31:0] res;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    int          exp_count;
    int          exp_drop;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 32'h40000000, 1'b0, 1'b1, 32'h40000000, 1, 0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 0};
    tbl[2]  = '{1'b1, 32'h1,        1'b0, 1'b1, 32'h1,        1, 0};
    tbl[3]  = '{1'b1, 32'h99,       1'b0, 1'b1, 32'h1,        1, 0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        1, 0};
    tbl[5]  = '{1'b1, 32'h2,        1'b0, 1'b1, 32'h1,        2, 0};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        2, 0};
    tbl[7]  = '{1'b1, 32'h3,        1'b0, 1'b1, 32'h1,        3, 0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        3, 0};
    tbl[9]  = '{1'b1, 32'h4,        1'b0, 1'b1, 32'h1,        4, 0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        4, 0};
    tbl[11] = '{1'b1, 32'h5,        1'b0, 1'b1, 32'h1,        4, 1};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h2,        3, 1};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h3,        2, 1};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1, 1};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1};

    // Power-on reset, released between edges.
    #2;
    check("por_out_valid", out_valid, 1'b0);
    check("por_count", count, 0);
    check("por_drop_cnt", drop_cnt, 0);
    check("por_out_data", out_data, 0);
    #11;
    RST = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].en, tbl[i].res, 1'b0, 1'b0, tbl[i].rdy);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_data", i), out_data, tbl[i].exp_data);
      check($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
      check($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].exp_drop);
    end

    // Enable held for ten cycles gives a single entry.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h3F800000 + i, 1'b1, 1'b0, 1'b0);
    check("held_count", count, 1);
    check("held_data", out_data, 32'h3F800000);
    check("held_ovf", out_ovf, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("held_drained", count, 0);

    // Full FIFO: push coincident with pop keeps count at DEPTH.
    for (int i = 1; i <= 4; i++) pulse(32'hA0 + i, 1'b0);
    check("full_count", count, 4);
    cycle(1'b1, 32'hA5, 1'b0, 1'b1, 1'b1);
    check("full_pushpop_count", count, 4);
    check("full_pushpop_head", out_data, 32'hA2);
    check("full_pushpop_drop", drop_cnt, 0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("full_order%0d", i), out_data, 32'hA0 + i);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    check("full_last_unf", out_unf, 1'b0);

    // Drop counter saturates at 255.
    for (int i = 0; i < 4; i++) pulse(32'h100 + i, 1'b0);
    for (int i = 0; i < 260; i++) pulse(32'h200 + i, 1'b0);
    check("drop_saturated", drop_cnt, 8'd255);
    check("drop_head_kept", out_data, 32'h100);

    // Reset mid-stream with three entries, enable already high when RST rises.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) pulse(32'h300 + i, 1'b0);
    check("pre_rst_count", count, 3);
    do_reset(1'b1);
    cycle(1'b1, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b0);
    check("post_rst_capture_valid", out_valid, 1'b1);
    check("post_rst_capture_data", out_data, 32'h7F7FFFFF);
    check("post_rst_capture_unf", out_unf, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

`ifdef FP_RESULT_CLASSIFY_EN
    do_reset(1'b0);
    cycle(1'b1, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    check("cls_inf_ovf", out_ovf, 1'b1);
    check("cls_inf", out_class, 3'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
    check("cls_zero", out_class, 3'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
    check("cls_nan", out_class, 3'd4);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0);
    check("cls_subnormal", out_class, 3'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hC0490FDB, 1'b0, 1'b0, 1'b0);
    check("cls_normal", out_class, 3'd2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model.
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 5))
        0:       v = 32'h00000000;
        1:       v = 32'h7F800000 | ($urandom_range(0, 1) << 31);
        2:       v = 32'h7FC00000 | $urandom_range(0, 255);
        3:       v = $urandom_range(1, 32'h7FFFFF);
        default: v = $urandom;
      endcase
      cycle(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_result_collect.md
FP_RESULT_COLLECT -- requirements
Module: fp_result_collect

Interface
REQ-001 DEPTH, 4, result FIFO entries; SHALL be a power of two in 2..16.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 result  input  32  IEEE754 single-precision result from the square stage.
REQ-005 overflow  input  1  square-stage overflow flag, qualified by enable.
REQ-006 underflow  input  1  square-stage underflow flag, qualified by enable.
REQ-007 enable  input  1  square stage done; result and flags valid while high.
REQ-008 out_data  output  32  head-of-FIFO result.
REQ-009 out_ovf  output  1  head-of-FIFO overflow flag.
REQ-010 out_unf  output  1  head-of-FIFO underflow flag.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 drop_cnt  output  8  saturating count of results lost to a full FIFO.

Function
REQ-015 Capture FSM SHALL have two states: IDLE (waiting for enable high) and HELD (enable high, already captured).
REQ-016 IDLE with enable=1: push {result, overflow, underflow}, go to HELD; HELD with enable=0: go to IDLE; otherwise stay.
REQ-017 An enable held high for any number of cycles SHALL produce exactly one push.
REQ-018 FIFO SHALL be first-word-fall-through: a push at edge N into an empty FIFO gives out_valid=1 after edge N; no same-cycle bypass.
REQ-019 Pop occurs when out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-020 Push and pop in the same cycle SHALL both be accepted, including when full; count is unchanged.
REQ-021 A push while full without a simultaneous pop SHALL drop the new entry, leave contents unchanged, and increment drop_cnt, saturating at 255.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 out_data, out_ovf and out_unf SHALL be 0 while out_valid=0.
REQ-024 Entries SHALL be delivered strictly in capture order.

Reset
REQ-025 RST low SHALL immediately clear out_valid, count, drop_cnt, out_data, out_ovf, out_unf (and out_class), pointers and FSM (to IDLE), regardless of clock.
REQ-026 Reset mid-stream SHALL discard all stored entries; storage array contents need not be cleared.
REQ-027 If enable is high on the first edge after RST rises, that result SHALL be captured.

Configuration
REQ-028 Macro FP_RESULT_CLASSIFY_EN defined: the block SHALL add output out_class (3 bits), computed at capture and stored per entry: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 NaN; out_class SHALL be 0 while empty.
REQ-029 Macro undefined: out_class is absent and the entry width is 34 bits.

Structure
REQ-030 Shared package fp_pkg SHALL hold EXP_W=8, MAN_W=23, BIAS=127, and the class encodings.
REQ-031 Classification SHALL live in combinational sub-module fp_classify, instantiated only under FP_RESULT_CLASSIFY_EN.

Verification
REQ-032 Reset, then a 1-cycle enable with result=32'h40000000 and flags 0 -> out_valid=1 after the next edge, out_data=40000000, count=1.
REQ-033 Enable held high for 10 cycles -> count=1, exactly one entry.
REQ-034 DEPTH=4, out_ready=0, five enable pulses (values 1..5) -> count=4, drop_cnt=1; draining yields 1,2,3,4.
REQ-035 FIFO full, enable rising edge with out_ready=1 in the same cycle -> count stays 4, head advances, new value appears last.
REQ-036 Macro defined: overflow=1 with 7F800000 -> out_ovf=1, class 3; 00000000 -> class 0; 7FC00000 -> class 4; 00000001 -> class 1.
REQ-037 RST low with 3 entries stored -> out_valid=0, count=0, drop_cnt=0 without waiting for a clock edge.
